// File: rtl/rvv_backend_alu_rs.sv
// ALU reservation station: in-order FIFO of uops between dispatch and the ALU.
// Up to PUSH_PORTS uops enter per cycle; the head is presented to the ALU and
// retires on pop_rs. A registered occupancy count is the single source of
// full/empty, so the pointers can wrap freely without any compare ambiguity.
module rvv_backend_alu_rs #(
    parameter type T          = logic [31:0],
    parameter int  DEPTH      = 8,
    parameter int  PUSH_PORTS = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [PUSH_PORTS-1:0]                  push_valid,
    input  logic [PUSH_PORTS-1:0][$bits(T)-1:0]    push_data,
    output logic                                   fifo_full,
    output logic                                   fifo_1left_to_full,
    output logic [$clog2(DEPTH):0]                 fifo_count,
    output logic                                   alu_uop_valid,
    output logic [$bits(T)-1:0]                    alu_uop,
    input  logic                                   pop_rs,
    input  logic                                   trap_flush_rvv
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $bits(T);

    logic [DW-1:0]         mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         free;
    logic [CW-1:0]         push_cnt;
    logic [PUSH_PORTS-1:0] accept;
    logic                  pop;

    // Free space comes only from the registered count; a same-cycle pop
    // never makes room for an extra push lane.
    assign free = CW'(DEPTH) - count;

    for (genvar g = 0; g < PUSH_PORTS; g++) begin : g_lane
        assign accept[g] = push_valid[g] && (CW'(g) < free);
    end

    // Number of lanes taken this cycle.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < PUSH_PORTS; i++) begin
            push_cnt = push_cnt + CW'(accept[i]);
        end
    end

    assign pop = pop_rs && (count != '0);

    // Pointer and occupancy update; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (trap_flush_rvv) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(push_cnt);
            count  <= count + push_cnt - CW'(pop);
        end
    end

    // Entry storage, deliberately not reset; lane i lands at wr_ptr+i.
    always_ff @(posedge clk) begin
        if (!trap_flush_rvv) begin
            for (int i = 0; i < PUSH_PORTS; i++) begin
                if (accept[i]) mem[wr_ptr + PW'(i)] <= push_data[i];
            end
        end
    end

    assign alu_uop_valid      = (count != '0);
    assign alu_uop            = alu_uop_valid ? mem[rd_ptr] : '0;
    assign fifo_count         = count;
    assign fifo_full          = (count == CW'(DEPTH));
    assign fifo_1left_to_full = (count >= CW'(DEPTH - 1));

`ifdef TB_SUPPORT
    for (genvar g = 1; g < PUSH_PORTS; g++) begin : g_contig
        a_contig: assert property (@(posedge clk) disable iff (!rst_n)
            !(push_valid[g] && !push_valid[g-1]));
    end
    a_space: assert property (@(posedge clk) disable iff (!rst_n)
        trap_flush_rvv || ((push_valid & ~accept) == '0));
    a_count: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH));
`endif

endmodule

// File: tb/tb_rvv_backend_alu_rs.sv
// Bench for the ALU reservation station: a queue model predicts the head,
// count and status every cycle; directed phases add literal expectations.
module tb_rvv_backend_alu_rs;

    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        push_valid = '0;
    logic [1:0][31:0]  push_data = '0;
    logic              fifo_full, fifo_1left_to_full;
    logic [3:0]        fifo_count;
    logic              alu_uop_valid;
    logic [31:0]       alu_uop;
    logic              pop_rs = 1'b0;
    logic              trap_flush_rvv = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [31:0] q[$];
    logic [31:0] popped[$];

    rvv_backend_alu_rs #(.T(logic [31:0]), .DEPTH(DEPTH), .PUSH_PORTS(2)) dut (
        .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_data(push_data),
        .fifo_full(fifo_full), .fifo_1left_to_full(fifo_1left_to_full),
        .fifo_count(fifo_count), .alu_uop_valid(alu_uop_valid), .alu_uop(alu_uop),
        .pop_rs(pop_rs), .trap_flush_rvv(trap_flush_rvv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a plain queue, flush and reset empty it.
    always @(posedge clk or negedge rst_n) begin
        int fr;
        if (!rst_n) q.delete();
        else if (trap_flush_rvv) q.delete();
        else begin
            fr = DEPTH - q.size();
            if (pop_rs && q.size() > 0) void'(q.pop_front());
            for (int i = 0; i < 2; i++)
                if (push_valid[i] && i < fr) q.push_back(push_data[i]);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [31:0] eu;
        eu = (q.size() != 0) ? q[0] : 32'h0;
        chk("m_valid", alu_uop_valid, q.size() != 0);
        chk("m_uop", alu_uop, eu);
        chk("m_count", fifo_count, q.size());
        chk("m_full", fifo_full, q.size() == DEPTH);
        chk("m_1left", fifo_1left_to_full, q.size() >= DEPTH - 1);
    end

    // Drive one cycle of inputs, recording a head that the DUT should retire.
    task automatic cyc(input logic [1:0] pv, input logic [31:0] d0, input logic [31:0] d1,
                       input logic p, input logic fl);
        push_valid = pv; push_data[0] = d0; push_data[1] = d1;
        pop_rs = p; trap_flush_rvv = fl;
        if (p && !fl && alu_uop_valid) popped.push_back(alu_uop);
        @(posedge clk); #1;
        push_valid = '0; pop_rs = 1'b0; trap_flush_rvv = 1'b0;
    endtask

    initial begin
        int next_tag, n, fr, guard;
        logic [1:0] pv;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle after reset, pop pulses ignored.
        for (int i = 0; i < 10; i++) begin
            cyc(2'b00, 0, 0, i[0], 1'b0);
            chk("idle_count", fifo_count, 0);
            chk("idle_uop", alu_uop, 0);
            chk("idle_valid", alu_uop_valid, 0);
        end

        // {A,B} with pop held.
        cyc(2'b11, 32'hA, 32'hB, 1'b1, 1'b0);
        chk("ab_head_a", alu_uop, 32'hA);
        cyc(2'b00, 0, 0, 1'b1, 1'b0);
        chk("ab_head_b", alu_uop, 32'hB);
        cyc(2'b00, 0, 0, 1'b1, 1'b0);
        chk("ab_empty", alu_uop_valid, 0);

        // Fill to full and overflow.
        cyc(2'b11, 32'h100, 32'h101, 1'b0, 1'b0);
        cyc(2'b11, 32'h102, 32'h103, 1'b0, 1'b0);
        cyc(2'b11, 32'h104, 32'h105, 1'b0, 1'b0);
        chk("fill6_1left", fifo_1left_to_full, 0);
        cyc(2'b01, 32'h106, 0, 1'b0, 1'b0);
        chk("fill7_1left", fifo_1left_to_full, 1);
        chk("fill7_full", fifo_full, 0);
        cyc(2'b01, 32'h107, 0, 1'b0, 1'b0);
        chk("fill8_full", fifo_full, 1);
        cyc(2'b11, 32'h1F0, 32'h1F1, 1'b0, 1'b0);
        chk("ovf_count", fifo_count, 8);
        chk("ovf_head", alu_uop, 32'h100);
        cyc(2'b00, 0, 0, 1'b1, 1'b0);
        chk("c7_count", fifo_count, 7);
        cyc(2'b11, 32'h108, 32'h109, 1'b1, 1'b0);
        chk("c7_push_pop_count", fifo_count, 7);
        chk("c7_push_pop_head", alu_uop, 32'h102);
        popped.delete();
        for (int i = 0; i < 7; i++) cyc(2'b00, 0, 0, 1'b1, 1'b0);
        chk("drain_n", popped.size(), 7);
        for (int i = 0; i < 7 && i < popped.size(); i++) chk("drain_order", popped[i], 32'h102 + i);

        // Random stream of 20 tags across pointer wrap.
        popped.delete();
        next_tag = 0; guard = 0;
        while (popped.size() < 20 && guard < 2000) begin
            fr = DEPTH - q.size();
            n = $urandom_range(0, 2);
            if (n > fr) n = fr;
            if (n > 20 - next_tag) n = 20 - next_tag;
            pv = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
            cyc(pv, next_tag, next_tag + 1, 1'($urandom_range(0, 1)), 1'b0);
            next_tag += n;
            guard++;
        end
        chk("stream_n", popped.size(), 20);
        for (int i = 0; i < 20 && i < popped.size(); i++) chk("stream_order", popped[i], i);
        chk("stream_empty", fifo_count, 0);

        // Flush with concurrent push and pop.
        cyc(2'b11, 32'h200, 32'h201, 1'b0, 1'b0);
        cyc(2'b11, 32'h202, 32'h203, 1'b0, 1'b0);
        cyc(2'b01, 32'h204, 0, 1'b0, 1'b0);
        chk("pre_flush_count", fifo_count, 5);
        cyc(2'b11, 32'h210, 32'h211, 1'b1, 1'b1);
        chk("flush_count", fifo_count, 0);
        chk("flush_valid", alu_uop_valid, 0);
        cyc(2'b01, 32'h300, 0, 1'b0, 1'b0);
        chk("post_flush_head", alu_uop, 32'h300);
        chk("post_flush_count", fifo_count, 1);

        // Asynchronous reset mid-operation.
        cyc(2'b11, 32'h400, 32'h401, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", alu_uop_valid, 0);
        chk("rst_uop", alu_uop, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(2'b01, 32'h500, 0, 1'b0, 1'b0);
        chk("post_rst_head", alu_uop, 32'h500);
        cyc(2'b00, 0, 0, 1'b1, 1'b0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
